// File: rtl/systolic_stream_ctrl.sv
// Byte-stream loader, start/wait sequencer and result drainer for the 4x4 systolic array.
// Matrices A then B arrive row-major as bytes; the 16 result words leave as a valid/ready stream.
module systolic_stream_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic [7:0]            i_inData,
  input  logic                  i_inValid,
  output logic                  o_inReady,
  output logic [3:0][3:0][7:0]  o_a,
  output logic [3:0][3:0][7:0]  o_b,
  output logic                  o_validInput,
  input  logic [3:0][3:0][15:0] i_c,
  input  logic                  i_validResult,
  output logic [15:0]           o_outData,
  output logic                  o_outValid,
  input  logic                  i_outReady,
  output logic                  o_outLast,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  // Abort when the incremented count would reach TIMEOUT-1, so the abort
  // pulse lands TIMEOUT cycles after the start pulse.
  localparam logic [7:0] WAIT_ABORT = 8'(TIMEOUT - 2);

  logic [2:0]            state;
  logic [3:0]            elem_idx;
  logic [3:0]            drain_idx;
  logic [7:0]            wait_cnt;
  logic [3:0][3:0][15:0] result_buf;
  logic                  in_xfer;

  assign in_xfer = i_inValid && o_inReady;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state        <= S_IDLE;
      elem_idx     <= '0;
      drain_idx    <= '0;
      wait_cnt     <= '0;
      result_buf   <= '0;
      o_a          <= '0;
      o_b          <= '0;
      o_validInput <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_validInput <= 1'b0;
      o_timeout    <= 1'b0;
      case (state)
        S_IDLE: state <= S_LOAD_A;
        S_LOAD_A, S_LOAD_B: begin
          if (in_xfer) begin
            if (state == S_LOAD_A) o_a[elem_idx[3:2]][elem_idx[1:0]] <= i_inData;
            else                   o_b[elem_idx[3:2]][elem_idx[1:0]] <= i_inData;
            elem_idx <= elem_idx + 4'd1;
            if (elem_idx == 4'd15) begin
              if (state == S_LOAD_A) begin
                state <= S_LOAD_B;
              end else begin
                state        <= S_START;
                o_validInput <= 1'b1;
              end
            end
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          // A result arriving on the abort cycle takes priority over the timeout.
          if (i_validResult) begin
            result_buf <= i_c;
            wait_cnt   <= '0;
            state      <= S_DRAIN;
          end else if (wait_cnt == WAIT_ABORT) begin
            wait_cnt  <= '0;
            o_timeout <= 1'b1;
            state     <= S_LOAD_A;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (i_outReady) begin
            drain_idx <= drain_idx + 4'd1;
            if (drain_idx == 4'd15) state <= S_LOAD_A;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_inReady  = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign o_busy     = (state == S_START) || (state == S_WAIT);
  assign o_outValid = (state == S_DRAIN);
  assign o_outLast  = (state == S_DRAIN) && (drain_idx == 4'd15);
  assign o_outData  = (state == S_DRAIN) ? result_buf[drain_idx[3:2]][drain_idx[1:0]] : 16'd0;

endmodule

// File: tb/tb_systolic_stream_ctrl.sv
// Self-checking bench for systolic_stream_ctrl: models the array, streams matrices in,
// and checks drained results against a plain matrix-multiply reference.
module tb_systolic_stream_ctrl;

  localparam int TIMEOUT = 15;

  typedef logic [7:0]  bytes_t [16];
  typedef logic [15:0] words_t [16];

  logic                  i_clk = 1'b0;
  logic                  i_arst_n;
  logic [7:0]            i_inData;
  logic                  i_inValid;
  logic                  o_inReady;
  logic [3:0][3:0][7:0]  o_a;
  logic [3:0][3:0][7:0]  o_b;
  logic                  o_validInput;
  logic [3:0][3:0][15:0] i_c;
  logic                  i_validResult;
  logic [15:0]           o_outData;
  logic                  o_outValid;
  logic                  i_outReady;
  logic                  o_outLast;
  logic                  o_busy;
  logic                  o_timeout;

  logic arr_valid = 1'b0;
  logic spurious_valid = 1'b0;
  logic array_en = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cnt = 0;
  int to_cnt = 0;
  int out_seen = 0;
  int in_hs = 0;
  int out_hs = 0;
  int pend = 0;
  int last_edge = 0;
  int load_cycles = 0;
  int first_out_cyc = 0;

  bytes_t a_bytes;
  bytes_t b_bytes;
  words_t exp_words;

  systolic_stream_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n),
    .i_inData(i_inData), .i_inValid(i_inValid), .o_inReady(o_inReady),
    .o_a(o_a), .o_b(o_b), .o_validInput(o_validInput),
    .i_c(i_c), .i_validResult(i_validResult),
    .o_outData(o_outData), .o_outValid(o_outValid), .i_outReady(i_outReady),
    .o_outLast(o_outLast), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  assign i_validResult = arr_valid | spurious_valid;

  // Array model: answers 10 cycles after sampling the start pulse, junk on i_c otherwise.
  always @(negedge i_clk) begin
    int acc;
    arr_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) i_c[i][j] = 16'($urandom);
    if (!i_arst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          arr_valid = 1'b1;
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
              acc = 0;
              for (int k = 0; k < 4; k++) acc += int'(o_a[i][k]) * int'(o_b[k][j]);
              i_c[i][j] = acc[15:0];
            end
        end
      end
      if (o_validInput && array_en) pend = 10;
    end
  end

  always @(negedge i_clk) begin
    if (o_validInput) start_cnt++;
    if (o_timeout)    to_cnt++;
    if (o_outValid)   out_seen++;
  end

  always @(posedge i_clk) begin
    cyc++;
    if (i_inValid && o_inReady) in_hs++;
    if (o_outValid && i_outReady) out_hs++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_bytes(input bytes_t v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = v[k];
    return r;
  endfunction

  task automatic compute_expected();
    int acc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc += int'(a_bytes[i*4+k]) * int'(b_bytes[k*4+j]);
        exp_words[i*4+j] = acc[15:0];
      end
  endtask

  task automatic randomize_bytes();
    for (int k = 0; k < 16; k++) begin
      a_bytes[k] = 8'($urandom);
      b_bytes[k] = 8'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inReady"},    o_inReady, 0);
    check({tag, "_outValid"},   o_outValid, 0);
    check({tag, "_outLast"},    o_outLast, 0);
    check({tag, "_validInput"}, o_validInput, 0);
    check({tag, "_timeout"},    o_timeout, 0);
    check({tag, "_busy"},       o_busy, 0);
    check({tag, "_outData"},    o_outData, 0);
    check({tag, "_a"},          o_a, 0);
    check({tag, "_b"},          o_b, 0);
  endtask

  // Streams all 32 bytes; returns at the negedge of the cycle after the last transfer.
  task automatic apply_stimulus(input int valid_pct, input int spur_idx);
    int  idx = 0;
    int  n = 0;
    int  c;
    bit  rdy, v;
    while (idx < 32 && n < 2000) begin
      @(negedge i_clk);
      rdy = o_inReady;
      c = cyc;
      v = ($urandom_range(99) < valid_pct);
      i_inValid = v;
      i_inData = v ? ((idx < 16) ? a_bytes[idx] : b_bytes[idx-16]) : 8'($urandom);
      spurious_valid = (idx == spur_idx);
      @(posedge i_clk);
      if (v && rdy) begin
        idx++;
        last_edge = c + 1;
      end
      n++;
    end
    load_cycles = n;
    @(negedge i_clk);
    i_inValid = 1'b0;
    spurious_valid = 1'b0;
    check("load_done", idx, 32);
  endtask

  task automatic check_start(input string tag);
    check({tag, "_start_pulse"}, o_validInput, 1);
    check({tag, "_busy_start"},  o_busy, 1);
    check({tag, "_a"},           o_a, pack_bytes(a_bytes));
    check({tag, "_b"},           o_b, pack_bytes(b_bytes));
  endtask

  task automatic check_output(input int ready_pct, input int stop_after);
    int got = 0;
    int n = 0;
    bit stalled = 1'b0;
    bit v, r;
    logic [15:0] pd = '0;
    logic pl = 1'b0;
    first_out_cyc = -1;
    while (got < stop_after && n < 3000) begin
      @(negedge i_clk);
      v = o_outValid;
      r = ($urandom_range(99) < ready_pct);
      if (stalled) begin
        check("drain_valid_hold",  o_outValid, 1);
        check("drain_data_stable", o_outData, pd);
        check("drain_last_stable", o_outLast, pl);
      end
      if (v) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        check($sformatf("drain_word%0d", got), o_outData, exp_words[got]);
        check($sformatf("drain_last%0d", got), o_outLast, (got == 15));
      end
      i_outReady = r;
      stalled = v && !r;
      pd = o_outData;
      pl = o_outLast;
      @(posedge i_clk);
      if (v && r) got++;
      n++;
    end
    check("drain_done", got, stop_after);
  endtask

  initial begin
    int s0, t0, o0, ih0, oh0, sc, n;
    bit seen;
    i_arst_n = 1'b0;
    i_inData = '0;
    i_inValid = 1'b0;
    i_outReady = 1'b0;

    // Reset state and first ready timing
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_arst_n = 1'b1;
    check("ready_before_edge1", o_inReady, 0);
    @(negedge i_clk);
    check("ready_after_edge1", o_inReady, 1);

    // Identity A times B = 1..16
    for (int k = 0; k < 16; k++) begin
      a_bytes[k] = (k / 4 == k % 4) ? 8'd1 : 8'd0;
      b_bytes[k] = 8'(k + 1);
      exp_words[k] = 16'(k + 1);
    end
    s0 = start_cnt;
    apply_stimulus(100, -1);
    check("ident_load_cycles", load_cycles, 32);
    check_start("ident");
    check_output(100, 16);
    check("ident_single_start", start_cnt - s0, 1);

    // All-2 times all-3 gives 24 everywhere; latency from last byte to first word
    for (int k = 0; k < 16; k++) begin
      a_bytes[k] = 8'd2;
      b_bytes[k] = 8'd3;
      exp_words[k] = 16'd24;
    end
    apply_stimulus(100, -1);
    check("const_load_cycles", load_cycles, 32);
    check_start("const");
    check_output(100, 16);
    check("const_latency", first_out_cyc - last_edge, 11);

    // Random data unstalled, then the same data with input/output gaps
    randomize_bytes();
    compute_expected();
    apply_stimulus(100, -1);
    check_start("rand");
    check_output(100, 16);
    ih0 = in_hs;
    oh0 = out_hs;
    apply_stimulus(50, -1);
    check_start("stall");
    check_output(70, 16);
    check("stall_in_handshakes",  in_hs - ih0, 32);
    check("stall_out_handshakes", out_hs - oh0, 16);

    // Silent array: timeout abort
    randomize_bytes();
    array_en = 1'b0;
    t0 = to_cnt;
    o0 = out_seen;
    apply_stimulus(100, -1);
    check_start("tmo");
    sc = cyc;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge i_clk);
      if (n == 0) check("tmo_busy_wait", o_busy, 1);
      if (o_timeout) begin
        seen = 1'b1;
        check("tmo_delay", cyc - sc, TIMEOUT);
        check("tmo_ready", o_inReady, 1);
      end
      n++;
    end
    check("tmo_seen", seen, 1);
    @(negedge i_clk);
    check("tmo_pulse_width", o_timeout, 0);
    check("tmo_single", to_cnt - t0, 1);
    check("tmo_no_output", out_seen - o0, 0);
    array_en = 1'b1;

    // Spurious result pulse during LOAD_B must be ignored
    randomize_bytes();
    compute_expected();
    apply_stimulus(100, 20);
    check_start("spur");
    check_output(100, 16);

    // Reset in the middle of the drain, then a full clean run
    randomize_bytes();
    compute_expected();
    apply_stimulus(100, -1);
    check_output(100, 7);
    @(negedge i_clk);
    i_arst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge i_clk);
    i_arst_n = 1'b1;
    randomize_bytes();
    compute_expected();
    apply_stimulus(100, -1);
    check_start("post_rst");
    check_output(60, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
